serial_pkt_rx: RTL and testbench
================================

Name: serial_pkt_rx

Overview:
- Serial packet receiver. It is the receive end of the team's LSB-first serial link, whose transmit side shifts out bit 0 of a parallel-in serial-out register first.
- Hunts for an 8-bit SYNC pattern, removes stuffed bits, and assembles data bytes.
- Presents each byte on a valid/ready output and reports packet start, clean end and errors.
- Sits between the line sampler (which produces bit strobes) and the packet/protocol FSM.

Parameters:
- SYNC_PAT, 8'h80: SYNC byte as assembled LSB-first (line order 0,0,0,0,0,0,0,1).
- STUFF_LEN, 6: number of consecutive 1s after which the next bit is a stuffed 0.
- CNT_W, 7: width of the per-packet byte counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_b  in  1  asynchronous active-low reset.
- bit_in  in  1  serial line bit; sampled only when bit_en=1.
- bit_en  in  1  one-cycle strobe marking a valid bit_in.
- eop  in  1  one-cycle end-of-packet strobe.
- byte_out  out  8  received byte; stable while byte_valid=1.
- byte_valid  out  1  byte available.
- byte_ready  in  1  consumer accepts; transfer occurs when valid&&ready.
- pkt_start  out  1  one-cycle pulse, SYNC matched.
- pkt_done  out  1  one-cycle pulse, clean EOP.
- pkt_err  out  1  one-cycle pulse at error detection.
- err_code  out  2  last error code; holds until the next pkt_start.
- byte_cnt  out  CNT_W  bytes completed in the current packet; saturates at all-ones.

Behaviour:
- Reset values:
  - State IDLE; sync window 8'h00; ones count 0; bit count 0.
  - All outputs 0; err_code ERR_NONE.
  - Reset asserted mid-packet aborts the packet immediately and produces no pulses.
- Bit order: data is LSB-first. Every shift is {bit, sr[7:1]}.
- IDLE:
  - On bit_en, shift bit_in into the window.
  - If the updated window equals SYNC_PAT, go to RECV. Next cycle: pkt_start=1, byte_cnt=0, err_code=ERR_NONE.
  - Set ones count to 1 (the SYNC's final 1 counts toward stuffing). Clear bit count. Clear the window.
  - eop in IDLE is ignored.
- RECV, on bit_en (eop not asserted):
  - If ones count == STUFF_LEN:
    - bit_in=0: discard the bit, ones count := 0.
    - bit_in=1: ERR_STUFF, go to ERR.
  - Otherwise: shift the bit into the data register, increment bit count, set ones count := bit_in ? ones+1 : 0.
  - When the 8th data bit shifts in:
    - If byte_valid=0, or byte_valid&&byte_ready this cycle: load byte_out and assert byte_valid next cycle (1-cycle latency). Increment byte_cnt. Bit count wraps to 0.
    - If byte_valid=1 and byte_ready=0: ERR_OVERRUN, go to ERR. The new byte is dropped; the held byte is kept until consumed.
- Output handshake:
  - byte_valid stays high until byte_ready is sampled high.
  - byte_valid falls the cycle after acceptance, unless a new byte loads that same cycle.
- EOP in RECV:
  - eop has priority over a same-cycle bit_en; that bit is ignored.
  - Bit count == 0: pkt_done pulse next cycle, go to IDLE.
  - Bit count != 0: ERR_ALIGN, pkt_err pulse, go to IDLE.
- ERR:
  - pkt_err pulses once, in the cycle after detection.
  - Further bits are ignored. eop returns to IDLE with no pkt_done.
  - A pending byte_valid still completes its handshake.
- Errors never clear byte_cnt; it reflects bytes completed before the error.

Optional Feature:
- Macro: SERIAL_RX_NRZI_DECODE_EN.
- Defined: bit_in is NRZI coded.
  - Decoded bit = (bit_in == prev_line) ? 1 : 0.
  - prev_line updates on each bit_en; it resets to 1 and is set to 1 on every eop.
  - SYNC matching, unstuffing and assembly all operate on the decoded bit.
- Undefined: bit_in is used raw; no prev_line register exists.

Decomposition:
- Package serial_rx_pkg:
  - rx_state_t enum {IDLE, RECV, ERR}.
  - rx_err_t 2-bit enum {ERR_NONE=0, ERR_STUFF=1, ERR_OVERRUN=2, ERR_ALIGN=3}.
  - SYNC_DEFAULT = 8'h80.
- Sub-module bit_unstuffer:
  - Inputs: bit, bit_en, clr_ones, preset_one.
  - Outputs: data_bit, data_en, stuff_err.
  - Owns the consecutive-ones counter.
- The top level uses the team's register primitive for byte_out and the sync window.

Test Plan:
- Reset, then line bits 0000000 1 then data 0xA5 LSB-first, then eop with ready=1:
  - pkt_start 1 cycle after the 8th SYNC bit.
  - byte_out=8'hA5 with valid 1 cycle after the last data bit.
  - byte_cnt=1, then pkt_done, err_code=0.
- Data 0xFF after SYNC:
  - The line carries 1,1,1,1,1 then stuffed 0 then 1,1,1.
  - Result: byte_out=8'hFF, 8 data bits counted, no error.
- SYNC followed by 1,1,1,1,1,1 (no stuffed 0):
  - ERR_STUFF, pkt_err pulse.
  - Later eop gives no pkt_done; state returns to IDLE.
- Two bytes 0x12, 0x34 with byte_ready held 0:
  - byte_out stays 0x12; ERR_OVERRUN on completion of 0x34.
  - Raising ready consumes 0x12 only.
- SYNC, 0x3C, then 3 extra bits, then eop: ERR_ALIGN, byte_cnt=1.
- rst_b low mid-byte: all outputs 0 asynchronously; the next SYNC is received normally.
- With SERIAL_RX_NRZI_DECODE_EN defined: NRZI-encoded SYNC+0x00 from idle-1 decodes to byte 0x00 and pkt_done.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Purpose: shared types and constants for the serial packet receiver.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_rx_pkg;

  // Receiver control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } rx_state_t;

  // Error codes reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STUFF   = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_ALIGN   = 2'd3
  } rx_err_t;

  // SYNC byte as assembled LSB-first (line order 0,0,0,0,0,0,0,1).
  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

  // LSB-first shift: the newest line bit enters at the top, so after eight
  // shifts the first bit on the line sits in bit 0.
  function automatic logic [7:0] lsb_shift(input logic [7:0] sr, input logic b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/bit_unstuffer.sv
// Purpose: removes the 0 inserted after STUFF_LEN consecutive 1s; flags a 1 there.
// Latency: combinational data path; only the ones counter is registered.
// Backpressure: none; every qualified input bit is consumed or discarded at once.
// Ports: bit_i/bit_en_i line bit + strobe, clr_ones_i hold counter at 0,
//        preset_one_i load counter with 1, data_bit_o/data_en_o payload bit,
//        stuff_err_o a 1 where a stuffed 0 was due.
module bit_unstuffer #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic bit_i,
  input  logic bit_en_i,
  input  logic clr_ones_i,
  input  logic preset_one_i,
  output logic data_bit_o,
  output logic data_en_o,
  output logic stuff_err_o
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  logic [OW-1:0] ones_q, ones_d;
  logic          at_limit;

  assign at_limit    = (ones_q == OW'(STUFF_LEN));
  assign data_bit_o  = bit_i;
  // At the limit the bit is a stuffing slot: never payload.
  assign data_en_o   = bit_en_i && !at_limit;
  assign stuff_err_o = bit_en_i && at_limit && bit_i;

  always_comb begin
    ones_d = ones_q;
    if (preset_one_i) begin
      // The SYNC ends in a 1, which counts toward the first run of ones.
      ones_d = OW'(1);
    end else if (clr_ones_i) begin
      ones_d = '0;
    end else if (bit_en_i) begin
      if (at_limit || !bit_i) begin
        ones_d = '0;
      end else begin
        ones_d = ones_q + OW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/serial_rx_reg.sv
// Purpose: generic enabled register with asynchronous active-low clear.
// Latency: 1 cycle from en_i/d_i to q_o.
// Backpressure: none; loads whenever en_i is high.
// Ports: clk_i clock, rst_b_i async clear, en_i load enable, d_i/q_o data.
module serial_rx_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_b_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/serial_pkt_rx.sv
// Purpose: LSB-first serial packet receiver: SYNC hunt, bit unstuffing, byte
//          assembly, packet start/done/error reporting.
// Latency: pkt_start/pkt_done/pkt_err and byte_valid rise 1 cycle after the
//          bit or eop that causes them.
// Backpressure: one held byte on valid/ready; a byte completing while the held
//          byte is unaccepted is dropped and reported as ERR_OVERRUN.
// Ports: clk, rst_b (async active-low); bit_in/bit_en line bit + strobe; eop
//        end-of-packet strobe; byte_out/byte_valid/byte_ready byte handshake;
//        pkt_start/pkt_done/pkt_err one-cycle pulses; err_code last error
//        (held until next pkt_start); byte_cnt saturating per-packet count.
// Build option: define SERIAL_RX_NRZI_DECODE_EN to NRZI-decode bit_in
//        (no transition = 1) before all other processing.
module serial_pkt_rx
  import serial_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_PAT  = SYNC_DEFAULT,
  parameter int         STUFF_LEN = 6,
  parameter int         CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             eop,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             pkt_start,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] byte_cnt
);

  rx_state_t        state_q, state_d;
  logic             rx_bit;
  logic [7:0]       win_q, win_d, win_shift;
  logic             win_en;
  logic             sync_hit;
  logic             ub_en;
  logic             data_bit, data_en, stuff_err;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       sr_q, sr_d, sr_shift;
  logic             load;
  logic             byte_valid_q, byte_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  rx_err_t          code_q, code_d;

  // ---------------------------------------------------------------------------
  // Line decode
  // ---------------------------------------------------------------------------
`ifdef SERIAL_RX_NRZI_DECODE_EN
  logic prev_line_q;

  // The line idles high, so every packet boundary restarts from 1.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_line_q <= 1'b1;
    end else if (eop) begin
      prev_line_q <= 1'b1;
    end else if (bit_en) begin
      prev_line_q <= bit_in;
    end
  end

  assign rx_bit = (bit_in == prev_line_q);
`else
  assign rx_bit = bit_in;
`endif

  // ---------------------------------------------------------------------------
  // SYNC hunt window (only shifts while idle; cleared on a hit)
  // ---------------------------------------------------------------------------
  assign win_shift = lsb_shift(win_q, rx_bit);
  assign sync_hit  = (state_q == IDLE) && bit_en && (win_shift == SYNC_PAT);
  assign win_en    = (state_q == IDLE) && bit_en;
  assign win_d     = sync_hit ? 8'h00 : win_shift;

  serial_rx_reg #(.W(8)) u_win_reg (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .en_i    (win_en),
    .d_i     (win_d),
    .q_o     (win_q)
  );

  // ---------------------------------------------------------------------------
  // Unstuffing: eop wins over a same-cycle bit, so that bit never reaches it.
  // ---------------------------------------------------------------------------
  assign ub_en = (state_q == RECV) && bit_en && !eop;

  bit_unstuffer #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
    .clk_i        (clk),
    .rst_b_i      (rst_b),
    .bit_i        (rx_bit),
    .bit_en_i     (ub_en),
    .clr_ones_i   (state_q != RECV),
    .preset_one_i (sync_hit),
    .data_bit_o   (data_bit),
    .data_en_o    (data_en),
    .stuff_err_o  (stuff_err)
  );

  assign sr_shift = lsb_shift(sr_q, data_bit);

  // ---------------------------------------------------------------------------
  // Control FSM (next state and pulses)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    load     = 1'b0;
    cnt_d    = cnt_q;
    code_d   = code_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_hit) begin
          state_d  = RECV;
          start_d  = 1'b1;
          cnt_d    = '0;
          code_d   = ERR_NONE;
          bitcnt_d = '0;
        end
      end

      RECV: begin
        if (eop) begin
          state_d = IDLE;
          if (bitcnt_q == 3'd0) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_ALIGN;
          end
        end else if (stuff_err) begin
          err_d   = 1'b1;
          code_d  = ERR_STUFF;
          state_d = ERR;
        end else if (data_en) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 3'd1;  // wraps to 0 on the 8th bit
          if (bitcnt_q == 3'd7) begin
            // The holding slot is free if empty or being drained this cycle.
            if (!byte_valid_q || byte_ready) begin
              load = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_OVERRUN;
              state_d = ERR;
            end
          end
        end
      end

      ERR: begin
        if (eop) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output byte holding register and handshake
  // ---------------------------------------------------------------------------
  serial_rx_reg #(.W(8)) u_byte_reg (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .en_i    (load),
    .d_i     (sr_shift),
    .q_o     (byte_out)
  );

  // A load in the acceptance cycle keeps valid high for the new byte.
  assign byte_valid_d = load || (byte_valid_q && !byte_ready);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      sr_q         <= '0;
      byte_valid_q <= 1'b0;
      cnt_q        <= '0;
      code_q       <= ERR_NONE;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      byte_valid_q <= byte_valid_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign pkt_start  = start_q;
  assign pkt_done   = done_q;
  assign pkt_err    = err_q;
  assign err_code   = code_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_pkt_rx.sv
// Bench for serial_pkt_rx: directed line vectors, expected events queued by
// the stimulus and popped/compared by an independent negedge monitor.
module tb_serial_pkt_rx;

  localparam int K_NONE  = 0;
  localparam int K_START = 1;
  localparam int K_BYTE  = 2;
  localparam int K_DONE  = 3;
  localparam int K_ERR   = 4;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       pkt_start, pkt_done, pkt_err;
  logic [1:0] err_code;
  logic [6:0] byte_cnt;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  logic tx_prev = 1'b1;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    logic [6:0] cnt;
    logic [1:0] code;
    int         t;
  } ev_t;

  ev_t exq[$];

  serial_pkt_rx dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .eop        (eop),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pkt_start  (pkt_start),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .err_code   (err_code),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] dat, input logic [6:0] cnt,
                           input logic [1:0] code, input int t);
    ev_t e;
    e.kind = kind; e.dat = dat; e.cnt = cnt; e.code = code; e.t = t;
    exq.push_back(e);
  endtask

  // Monitor: every DUT-presented event must match the head of the queue.
  task automatic take(input int k);
    ev_t e;
    if (exq.size() == 0) begin
      chk("evt_unexpected", k, K_NONE);
    end else begin
      e = exq.pop_front();
      chk("evt_kind", k, e.kind);
      if (k == e.kind) begin
        if (k == K_BYTE) chk("byte_dat_cnt", {byte_out, byte_cnt}, {e.dat, e.cnt});
        else             chk("evt_code_cnt", {err_code, byte_cnt}, {e.code, e.cnt});
      end
      if (e.t >= 0) chk("evt_cycle", cyc, e.t);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      if (pkt_start) take(K_START);
      if (byte_valid && byte_ready) take(K_BYTE);
      if (pkt_done) take(K_DONE);
      if (pkt_err) take(K_ERR);
    end
  end

  // All drivers run from posedge+1 and return at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    logic line;
`ifdef SERIAL_RX_NRZI_DECODE_EN
    line = b ? tx_prev : ~tx_prev;  // 1 = no transition
    tx_prev = line;
`else
    line = b;
`endif
    bit_in = line;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_sync();
    send_bits(16'h0080, 8);
    expect_ev(K_START, 8'h00, 7'd0, 2'd0, cyc);
  endtask

  task automatic send_eop();
    eop = 1'b1;
    @(posedge clk); #1;
    eop = 1'b0;
    tx_prev = 1'b1;
  endtask

  initial begin
    #2 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {byte_out, byte_valid, pkt_start, pkt_done, pkt_err, err_code, byte_cnt}, 0);
    rst_b = 1'b1;
    idle(2);

    // Basic packet: SYNC, 0xA5, clean eop.
    byte_ready = 1'b1;
    send_sync();
    send_bits(16'h00A5, 8);
    expect_ev(K_BYTE, 8'hA5, 7'd1, 2'd0, cyc);
    idle(2);
    send_eop();
    expect_ev(K_DONE, 8'h00, 7'd1, 2'd0, cyc);
    idle(2);

    // 0xFF with a stuffed 0 after five data ones (SYNC's 1 makes six).
    send_sync();
    send_bits(16'h01DF, 9);
    expect_ev(K_BYTE, 8'hFF, 7'd1, 2'd0, cyc);
    idle(2);
    send_eop();
    expect_ev(K_DONE, 8'h00, 7'd1, 2'd0, cyc);
    idle(2);

    // Missing stuffed 0: stuff error, later eop gives no done.
    send_sync();
    send_bits(16'h003F, 6);
    expect_ev(K_ERR, 8'h00, 7'd0, 2'd1, cyc);
    idle(2);
    send_eop();
    idle(2);
    chk("err_code_hold", err_code, 2'd1);

    // Overrun: 0x12 held, 0x34 dropped.
    byte_ready = 1'b0;
    send_sync();
    send_bits(16'h0012, 8);
    send_bits(16'h0034, 8);
    expect_ev(K_ERR, 8'h00, 7'd1, 2'd2, cyc);
    idle(1);
    chk("ovr_hold", {byte_valid, byte_out}, {1'b1, 8'h12});
    expect_ev(K_BYTE, 8'h12, 7'd1, 2'd2, -1);
    byte_ready = 1'b1;
    idle(4);
    chk("ovr_drained", byte_valid, 1'b0);
    send_eop();
    idle(2);

    // Misaligned eop after 0x3C plus 3 bits.
    send_sync();
    send_bits(16'h003C, 8);
    expect_ev(K_BYTE, 8'h3C, 7'd1, 2'd0, cyc);
    send_bits(16'h0002, 3);
    send_eop();
    expect_ev(K_ERR, 8'h00, 7'd1, 2'd3, cyc);
    idle(2);

    // Asynchronous reset mid-byte with a byte still held.
    byte_ready = 1'b0;
    send_sync();
    send_bits(16'h005A, 8);
    send_bits(16'h000A, 4);
    chk("pre_rst_state", {byte_valid, byte_out, byte_cnt}, {1'b1, 8'h5A, 7'd1});
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst", {byte_out, byte_valid, pkt_start, pkt_done, pkt_err, err_code, byte_cnt}, 0);
    tx_prev = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b1;
    byte_ready = 1'b1;
    idle(1);
    send_sync();
    send_bits(16'h00C3, 8);
    expect_ev(K_BYTE, 8'hC3, 7'd1, 2'd0, cyc);
    idle(2);
    send_eop();
    expect_ev(K_DONE, 8'h00, 7'd1, 2'd0, cyc);
    idle(2);

    // SYNC + 0x00 (an all-transition line when NRZI coded).
    send_sync();
    send_bits(16'h0000, 8);
    expect_ev(K_BYTE, 8'h00, 7'd1, 2'd0, cyc);
    idle(2);
    send_eop();
    expect_ev(K_DONE, 8'h00, 7'd1, 2'd0, cyc);

    idle(4);
    chk("evq_empty", exq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
